// File: rtl/memory_island_bank_arbiter.sv
// Per-bank port arbiter: shares one single-ported SRAM bank between round-robin narrow
// requesters and a wide slice, and routes each response back to its originator.
module memory_island_bank_arbiter #(
  parameter int NumNarrow        = 2,
  parameter int AddrWidth        = 10,
  parameter int DataWidth        = 64,
  parameter int MemLatency       = 1,
  parameter int WidePriorityWait = 0,
  localparam int StrbWidth = DataWidth / 8,
  localparam int PtrWidth  = (NumNarrow > 1) ? $clog2(NumNarrow) : 1,
  localparam int WaitWidth = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumNarrow-1:0]           narrow_req_i,
  output logic [NumNarrow-1:0]           narrow_gnt_o,
  input  logic [NumNarrow*AddrWidth-1:0] narrow_addr_i,
  input  logic [NumNarrow-1:0]           narrow_we_i,
  input  logic [NumNarrow*DataWidth-1:0] narrow_wdata_i,
  input  logic [NumNarrow*StrbWidth-1:0] narrow_strb_i,
  output logic [NumNarrow-1:0]           narrow_rvalid_o,
  output logic [DataWidth-1:0]           narrow_rdata_o,
  input  logic                           wide_req_i,
  output logic                           wide_gnt_o,
  input  logic [AddrWidth-1:0]           wide_addr_i,
  input  logic                           wide_we_i,
  input  logic [DataWidth-1:0]           wide_wdata_i,
  input  logic [StrbWidth-1:0]           wide_strb_i,
  output logic                           wide_rvalid_o,
  output logic [DataWidth-1:0]           wide_rdata_o,
  output logic                           bank_req_o,
  output logic                           bank_we_o,
  output logic [AddrWidth-1:0]           bank_addr_o,
  output logic [DataWidth-1:0]           bank_wdata_o,
  output logic [StrbWidth-1:0]           bank_strb_o,
  input  logic [DataWidth-1:0]           bank_rdata_i,
  output logic [PtrWidth-1:0]            dbg_rr_ptr_o,
  output logic [WaitWidth-1:0]           dbg_wait_o
);

  localparam int Last = MemLatency - 1;
  localparam logic [WaitWidth-1:0] WaitMax = WaitWidth'(WidePriorityWait);

  logic [PtrWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WaitWidth-1:0]  wait_q, wait_d;
  logic [MemLatency-1:0] pipe_valid_q, pipe_valid_d;
  logic [MemLatency-1:0] pipe_wide_q, pipe_wide_d;
  logic [PtrWidth-1:0]   pipe_idx_q [MemLatency];
  logic [PtrWidth-1:0]   pipe_idx_d [MemLatency];

  logic                  narrow_any;
  logic                  narrow_win_gnt;
  logic                  wide_force;
  logic [PtrWidth-1:0]   narrow_win;
  int                    cand;

  // Round-robin search starting at rr_ptr, then the starvation override on top.
  always_comb begin
    narrow_any = 1'b0;
    narrow_win = '0;
    cand       = 0;
    for (int k = 0; k < NumNarrow; k++) begin
      cand = (int'(rr_ptr_q) + k) % NumNarrow;
      if (!narrow_any && narrow_req_i[cand]) begin
        narrow_any = 1'b1;
        narrow_win = PtrWidth'(cand);
      end
    end
    wide_force     = (WidePriorityWait != 0) && wide_req_i && (wait_q == WaitMax);
    narrow_win_gnt = narrow_any && !wide_force;
    wide_gnt_o     = wide_req_i && (wide_force || !narrow_any);
    narrow_gnt_o   = '0;
    if (narrow_win_gnt) narrow_gnt_o[narrow_win] = 1'b1;
  end

  always_comb begin
    bank_req_o   = wide_gnt_o | narrow_win_gnt;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_strb_o  = '0;
    if (wide_gnt_o) begin
      bank_we_o    = wide_we_i;
      bank_addr_o  = wide_addr_i;
      bank_wdata_o = wide_wdata_i;
      bank_strb_o  = wide_strb_i;
    end
    for (int i = 0; i < NumNarrow; i++) begin
      if (narrow_gnt_o[i]) begin
        bank_we_o    = narrow_we_i[i];
        bank_addr_o  = narrow_addr_i[i*AddrWidth +: AddrWidth];
        bank_wdata_o = narrow_wdata_i[i*DataWidth +: DataWidth];
        bank_strb_o  = narrow_strb_i[i*StrbWidth +: StrbWidth];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (narrow_win_gnt) begin
      rr_ptr_d = (int'(narrow_win) == NumNarrow - 1) ? '0 : narrow_win + PtrWidth'(1);
    end
    wait_d = wait_q;
    if (!wide_req_i || wide_gnt_o) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + WaitWidth'(1);
    end
  end

  // Stage 0 captures this cycle's grant; the last stage names the response owner.
  always_comb begin
    pipe_valid_d    = pipe_valid_q;
    pipe_wide_d     = pipe_wide_q;
    pipe_idx_d      = pipe_idx_q;
    pipe_valid_d[0] = bank_req_o;
    pipe_wide_d[0]  = wide_gnt_o;
    pipe_idx_d[0]   = narrow_win;
    for (int s = 1; s < MemLatency; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_wide_d[s]  = pipe_wide_q[s-1];
      pipe_idx_d[s]   = pipe_idx_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      wait_q       <= '0;
      pipe_valid_q <= '0;
      pipe_wide_q  <= '0;
      for (int s = 0; s < MemLatency; s++) pipe_idx_q[s] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wait_q       <= wait_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_wide_q  <= pipe_wide_d;
      for (int s = 0; s < MemLatency; s++) pipe_idx_q[s] <= pipe_idx_d[s];
    end
  end

  always_comb begin
    wide_rvalid_o = pipe_valid_q[Last] & pipe_wide_q[Last];
    for (int i = 0; i < NumNarrow; i++) begin
      narrow_rvalid_o[i] = pipe_valid_q[Last] & ~pipe_wide_q[Last] &
                           (pipe_idx_q[Last] == PtrWidth'(i));
    end
  end

  assign narrow_rdata_o = bank_rdata_i;
  assign wide_rdata_o   = bank_rdata_i;
  assign dbg_rr_ptr_o   = rr_ptr_q;
  assign dbg_wait_o     = wait_q;

endmodule

// File: tb/tb_memory_island_bank_arbiter.sv
// Bench for memory_island_bank_arbiter: instance "a" (3 narrow, latency 2, wait 3) with an SRAM
// model, instance "b" (defaults, strict narrow priority).
module tb_memory_island_bank_arbiter;
  localparam int AN = 3, AW = 10, DW = 64, SW = 8, AL = 2, AWAIT = 3, BN = 2;
  localparam logic [7:0] NONE = 8'hFF, WIDE = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AN-1:0]    a_nreq, a_nwe, a_ngnt, a_nrvalid;
  logic [AN*AW-1:0] a_naddr;
  logic [AN*DW-1:0] a_nwdata;
  logic [AN*SW-1:0] a_nstrb;
  logic [DW-1:0]    a_nrdata, a_wwdata, a_wrdata, a_bwdata, a_brdata;
  logic             a_wreq, a_wgnt, a_wwe, a_wrvalid, a_breq, a_bwe;
  logic [AW-1:0]    a_waddr, a_baddr;
  logic [SW-1:0]    a_wstrb, a_bstrb;
  logic [1:0]       a_dbg_rr, a_dbg_wait;

  logic [BN-1:0]    b_nreq, b_nwe, b_ngnt, b_nrvalid;
  logic [BN*AW-1:0] b_naddr;
  logic [BN*DW-1:0] b_nwdata;
  logic [BN*SW-1:0] b_nstrb;
  logic [DW-1:0]    b_nrdata, b_wwdata, b_wrdata, b_bwdata, b_brdata;
  logic             b_wreq, b_wgnt, b_wwe, b_wrvalid, b_breq, b_bwe;
  logic [AW-1:0]    b_waddr, b_baddr;
  logic [SW-1:0]    b_wstrb, b_bstrb;
  logic             b_dbg_rr, b_dbg_wait;

  memory_island_bank_arbiter #(.NumNarrow(AN), .AddrWidth(AW), .DataWidth(DW),
    .MemLatency(AL), .WidePriorityWait(AWAIT)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .narrow_req_i(a_nreq), .narrow_gnt_o(a_ngnt), .narrow_addr_i(a_naddr),
    .narrow_we_i(a_nwe), .narrow_wdata_i(a_nwdata), .narrow_strb_i(a_nstrb),
    .narrow_rvalid_o(a_nrvalid), .narrow_rdata_o(a_nrdata),
    .wide_req_i(a_wreq), .wide_gnt_o(a_wgnt), .wide_addr_i(a_waddr), .wide_we_i(a_wwe),
    .wide_wdata_i(a_wwdata), .wide_strb_i(a_wstrb), .wide_rvalid_o(a_wrvalid),
    .wide_rdata_o(a_wrdata),
    .bank_req_o(a_breq), .bank_we_o(a_bwe), .bank_addr_o(a_baddr), .bank_wdata_o(a_bwdata),
    .bank_strb_o(a_bstrb), .bank_rdata_i(a_brdata),
    .dbg_rr_ptr_o(a_dbg_rr), .dbg_wait_o(a_dbg_wait));

  memory_island_bank_arbiter #(.NumNarrow(BN), .AddrWidth(AW), .DataWidth(DW),
    .MemLatency(1), .WidePriorityWait(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .narrow_req_i(b_nreq), .narrow_gnt_o(b_ngnt), .narrow_addr_i(b_naddr),
    .narrow_we_i(b_nwe), .narrow_wdata_i(b_nwdata), .narrow_strb_i(b_nstrb),
    .narrow_rvalid_o(b_nrvalid), .narrow_rdata_o(b_nrdata),
    .wide_req_i(b_wreq), .wide_gnt_o(b_wgnt), .wide_addr_i(b_waddr), .wide_we_i(b_wwe),
    .wide_wdata_i(b_wwdata), .wide_strb_i(b_wstrb), .wide_rvalid_o(b_wrvalid),
    .wide_rdata_o(b_wrdata),
    .bank_req_o(b_breq), .bank_we_o(b_bwe), .bank_addr_o(b_baddr), .bank_wdata_o(b_bwdata),
    .bank_strb_o(b_bstrb), .bank_rdata_i(b_brdata),
    .dbg_rr_ptr_o(b_dbg_rr), .dbg_wait_o(b_dbg_wait));

  // SRAM behind instance a: byte-strobed writes, reads appear AL cycles after the request.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_pipe [AL];
  always @(posedge clk) begin
    if (a_breq && a_bwe)
      for (int b = 0; b < SW; b++)
        if (a_bstrb[b]) mem[a_baddr][b*8 +: 8] <= a_bwdata[b*8 +: 8];
    rd_pipe[0] <= (a_breq && !a_bwe) ? mem[a_baddr] : '0;
    for (int s = 1; s < AL; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign a_brdata = rd_pipe[AL-1];
  assign b_brdata = '0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_a();
    a_nreq = '0; a_nwe = '0; a_naddr = '0; a_nwdata = '0; a_nstrb = '0;
    a_wreq = 1'b0; a_wwe = 1'b0; a_waddr = '0; a_wwdata = '0; a_wstrb = '0;
  endtask

  task automatic clear_b();
    b_nreq = '0; b_nwe = '0; b_naddr = '0; b_nwdata = '0; b_nstrb = '0;
    b_wreq = 1'b0; b_wwe = 1'b0; b_waddr = '0; b_wwdata = '0; b_wstrb = '0;
  endtask

  // Returns at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_a();
    clear_b();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] nreq;
    logic       wreq;
    logic [2:0] ngnt;
    logic       wgnt;
    logic [1:0] rr;
  } vec_t;

  vec_t       tab [12];
  logic [2:0] st_ng [5];
  logic       st_wg [5];
  logic [1:0] st_wait [5];

  int         rr_m, waited_m, idx;
  logic [7:0] code, front;
  logic [7:0] exp_q [$];
  logic [2:0] exp_ng, exp_nrv;
  logic [AW-1:0] exp_addr;

  initial begin
    tab[0]  = '{3'b111, 1'b0, 3'b001, 1'b0, 2'd0};
    tab[1]  = '{3'b111, 1'b0, 3'b010, 1'b0, 2'd1};
    tab[2]  = '{3'b111, 1'b0, 3'b100, 1'b0, 2'd2};
    tab[3]  = '{3'b111, 1'b0, 3'b001, 1'b0, 2'd0};
    tab[4]  = '{3'b111, 1'b0, 3'b010, 1'b0, 2'd1};
    tab[5]  = '{3'b111, 1'b0, 3'b100, 1'b0, 2'd2};
    tab[6]  = '{3'b000, 1'b0, 3'b000, 1'b0, 2'd0};
    tab[7]  = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd0};
    tab[8]  = '{3'b101, 1'b0, 3'b001, 1'b0, 2'd0};
    tab[9]  = '{3'b101, 1'b0, 3'b100, 1'b0, 2'd1};
    tab[10] = '{3'b110, 1'b0, 3'b010, 1'b0, 2'd0};
    tab[11] = '{3'b011, 1'b0, 3'b001, 1'b0, 2'd2};
    st_ng   = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
    st_wg   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    st_wait = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state; grants still follow requests combinationally.
    rst_n = 1'b0;
    clear_a();
    clear_b();
    a_nreq = 3'b010;
    #3;
    check("rst_ngnt", 64'(a_ngnt), 64'(3'b010));
    check("rst_breq", 64'(a_breq), 64'(1'b1));
    check("rst_nrvalid", 64'(a_nrvalid), 64'(0));
    check("rst_wrvalid", 64'(a_wrvalid), 64'(0));
    check("rst_rr", 64'(a_dbg_rr), 64'(0));
    check("rst_wait", 64'(a_dbg_wait), 64'(0));
    check("rst_b_rvalid", 64'({b_nrvalid, b_wrvalid}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table: round-robin, idle, wide-only and sparse patterns; responses AL cycles later.
    for (int k = 0; k < 12; k++) begin
      a_nreq = tab[k].nreq;
      a_wreq = tab[k].wreq;
      #2;
      check("tab_ngnt", 64'(a_ngnt), 64'(tab[k].ngnt));
      check("tab_wgnt", 64'(a_wgnt), 64'(tab[k].wgnt));
      check("tab_breq", 64'(a_breq), 64'(|tab[k].ngnt | tab[k].wgnt));
      check("tab_rr", 64'(a_dbg_rr), 64'(tab[k].rr));
      if (k >= AL) begin
        check("tab_nrvalid", 64'(a_nrvalid), 64'(tab[k-AL].ngnt));
        check("tab_wrvalid", 64'(a_wrvalid), 64'(tab[k-AL].wgnt));
      end else begin
        check("tab_nrvalid", 64'(a_nrvalid), 64'(0));
        check("tab_wrvalid", 64'(a_wrvalid), 64'(0));
      end
      @(negedge clk);
    end

    // Reset with two reads in flight: both responses must vanish.
    clear_a();
    a_nreq = 3'b001;
    @(negedge clk);
    a_nreq = 3'b010;
    @(negedge clk);
    a_nreq = 3'b000;
    rst_n  = 1'b0;
    #2;
    check("midrst_nrvalid", 64'(a_nrvalid), 64'(0));
    check("midrst_rr", 64'(a_dbg_rr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("midrst_after_nrvalid", 64'(a_nrvalid), 64'(0));
      check("midrst_after_wrvalid", 64'(a_wrvalid), 64'(0));
      check("midrst_after_rr", 64'(a_dbg_rr), 64'(0));
      @(negedge clk);
    end

    // Starvation: wide wins on its fourth blocked cycle.
    a_nreq = 3'b001;
    a_wreq = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("starve_ngnt", 64'(a_ngnt), 64'(st_ng[c]));
      check("starve_wgnt", 64'(a_wgnt), 64'(st_wg[c]));
      check("starve_wait", 64'(a_dbg_wait), 64'(st_wait[c]));
      @(negedge clk);
    end

    // Data path: wide write to addr 5, narrow 1 reads it back.
    a_nreq = '0;
    a_wwe = 1'b1; a_waddr = 10'd5; a_wwdata = 64'hDEAD_BEEF_0000_0001; a_wstrb = 8'hFF;
    #2;
    check("dp_wgnt", 64'(a_wgnt), 64'(1));
    check("dp_bwe", 64'(a_bwe), 64'(1));
    check("dp_baddr", 64'(a_baddr), 64'(5));
    check("dp_bwdata", a_bwdata, 64'hDEAD_BEEF_0000_0001);
    check("dp_bstrb", 64'(a_bstrb), 64'(8'hFF));
    @(negedge clk);
    a_wreq = 1'b0; a_wwe = 1'b0; a_wstrb = '0; a_wwdata = '0;
    a_nreq = 3'b010; a_naddr[1*AW +: AW] = 10'd5;
    #2;
    check("dp_rd_ngnt", 64'(a_ngnt), 64'(3'b010));
    check("dp_rd_bwe", 64'(a_bwe), 64'(0));
    check("dp_rd_baddr", 64'(a_baddr), 64'(5));
    check("dp_rd_bwdata", a_bwdata, 64'(0));
    @(negedge clk);
    a_nreq = '0;
    #2;
    check("dp_wr_rsp", 64'(a_wrvalid), 64'(1));
    check("dp_wr_rsp_n", 64'(a_nrvalid), 64'(0));
    @(negedge clk);
    #2;
    check("dp_rd_rsp", 64'(a_nrvalid), 64'(3'b010));
    check("dp_rd_rsp_w", 64'(a_wrvalid), 64'(0));
    check("dp_rd_data", a_nrdata, 64'hDEAD_BEEF_0000_0001);
    check("dp_wide_fanout", a_wrdata, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);

    // Idle: nothing moves, pointer keeps its value (2 after the narrow 1 grant).
    for (int c = 0; c < 5; c++) begin
      #2;
      check("idle_breq", 64'(a_breq), 64'(0));
      check("idle_gnt", 64'({a_ngnt, a_wgnt}), 64'(0));
      check("idle_rvalid", 64'({a_nrvalid, a_wrvalid}), 64'(0));
      check("idle_rr", 64'(a_dbg_rr), 64'(2));
      @(negedge clk);
    end

    // Random traffic against an owner-queue reference model.
    do_reset();
    rr_m = 0;
    waited_m = 0;
    exp_q.delete();
    for (int s = 0; s < AL; s++) exp_q.push_back(NONE);
    for (int c = 0; c < 400; c++) begin
      a_nreq   = 3'($urandom_range(0, 7));
      a_wreq   = 1'($urandom_range(0, 1));
      a_nwe    = 3'($urandom_range(0, 7));
      a_wwe    = 1'($urandom_range(0, 1));
      a_naddr  = 30'($urandom);
      a_waddr  = 10'($urandom);
      a_nstrb  = 24'($urandom);
      a_wstrb  = 8'($urandom);
      code = NONE;
      if (a_wreq && waited_m >= AWAIT) begin
        code = WIDE;
      end else begin
        for (int k = 0; k < AN; k++) begin
          idx = (rr_m + k) % AN;
          if (code == NONE && a_nreq[idx]) code = 8'(idx);
        end
        if (code == NONE && a_wreq) code = WIDE;
      end
      exp_ng   = (code < 8'(AN)) ? 3'(1 << code) : 3'b000;
      exp_addr = (code < 8'(AN)) ? a_naddr[code*AW +: AW] : ((code == WIDE) ? a_waddr : '0);
      front    = exp_q[0];
      exp_nrv  = (front < 8'(AN)) ? 3'(1 << front) : 3'b000;
      #2;
      check("rnd_ngnt", 64'(a_ngnt), 64'(exp_ng));
      check("rnd_wgnt", 64'(a_wgnt), 64'(code == WIDE));
      check("rnd_breq", 64'(a_breq), 64'(code != NONE));
      check("rnd_baddr", 64'(a_baddr), 64'(exp_addr));
      check("rnd_nrvalid", 64'(a_nrvalid), 64'(exp_nrv));
      check("rnd_wrvalid", 64'(a_wrvalid), 64'(front == WIDE));
      if (code < 8'(AN)) rr_m = (int'(code) + 1) % AN;
      if (a_wreq && code != WIDE) waited_m = (waited_m < AWAIT) ? waited_m + 1 : AWAIT;
      else waited_m = 0;
      void'(exp_q.pop_front());
      exp_q.push_back(code);
      @(negedge clk);
    end
    clear_a();

    // Strict narrow priority on instance b.
    b_nreq = 2'b01;
    b_wreq = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #2;
      check("strict_wgnt", 64'(b_wgnt), 64'(0));
      check("strict_ngnt", 64'(b_ngnt), 64'(2'b01));
      @(negedge clk);
    end
    b_nreq = 2'b00;
    #2;
    check("strict_wide_wins", 64'(b_wgnt), 64'(1));
    check("strict_wait", 64'(b_dbg_wait), 64'(0));
    @(negedge clk);
    b_wreq = 1'b0;
    #2;
    check("strict_wrvalid", 64'(b_wrvalid), 64'(1));
    check("strict_nrvalid", 64'(b_nrvalid), 64'(0));
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
